flog_out_packer: RTL and testbench

//  Output stage of the bfloat16 log unit. Takes the signed fixed-point log result and the 6-bit

---
 rtl/flog_out_packer.sv | 192 +++++++++++++++++++
 tb/tb_flog_out_packer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flog_out_packer.sv
// -----------------------------------------------------------------------------
// flog_out_packer
//   Output stage of the bfloat16 log unit. Converts the signed fixed-point log
//   result into a bfloat16 value, or substitutes the special encoding selected
//   by the special-case vector. Two-entry valid/ready pipeline:
//     stage 1 registers sign, |res| and the resolved special code,
//     stage 2 registers the normalized, rounded bfloat16 word.
//
//   Ports
//     clk_i     in   1     clock, rising edge
//     rst_i     in   1     asynchronous reset, active-high
//     valid_i   in   1     upstream result valid
//     ready_o   out  1     block accepts res_i/spec_i
//     res_i     in   DIM   signed Q(DIM-COMMA_POS).COMMA_POS log result
//     spec_i    in   6     {isNeg,isPosInf,isPosZero,isQNaN,isSNaN,isOpValid}
//     valid_o   out  1     result_o valid
//     ready_i   in   1     downstream accepts result_o
//     result_o  out  16    bfloat16 {s,exp[7:0],fract[6:0]}
//     flags_o   out  3     {invalid,divzero,inexact}, only with FLOG_PACK_STATUS_EN
//
//   Configuration macro: FLOG_PACK_STATUS_EN adds the flags_o status port.
// -----------------------------------------------------------------------------

package flog_pkg;
    localparam int DIM         = 22;
    localparam int COMMA_POS   = 14;
    localparam int EXP_WIDTH   = 8;
    localparam int FRACT_WIDTH = 7;
    localparam int BIAS        = 127;
endpackage

module flog_out_packer
    import flog_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [DIM-1:0]   res_i,
    input  logic [5:0]       spec_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [15:0]      result_o
`ifdef FLOG_PACK_STATUS_EN
    ,
    output logic [2:0]       flags_o
`endif
);

    localparam int LW = $clog2(DIM);

    // Special-case vector bit positions.
    localparam int S_NEG  = 5;
    localparam int S_PINF = 4;
    localparam int S_PZER = 3;
    localparam int S_QNAN = 2;
    localparam int S_SNAN = 1;

    // ---------------- handshake ----------------
    logic v1_q, v2_q;
    logic en1, en2;

    // Stage 2 may load when empty or draining; stage 1 may load when empty or
    // when its content moves on in the same cycle.
    assign en2     = ~v2_q | ready_i;
    assign en1     = ~v1_q | en2;
    assign ready_o = en1;
    assign valid_o = v2_q;

    // ---------------- stage 1 ----------------
    logic            sign_d,    sign_q;
    logic [DIM-1:0]  mag_d,     mag_q;
    logic            special_d, special_q;
    logic [15:0]     code_d,    code_q;

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        sign_d    = res_i[DIM-1];
        // Two's-complement negate; -2^(DIM-1) maps to 2^(DIM-1) as unsigned.
        mag_d     = sign_d ? (~res_i + 1'b1) : res_i;
        special_d = 1'b1;
        code_d    = 16'h0000;
        if (spec_i[S_SNAN] | spec_i[S_QNAN] | spec_i[S_NEG]) begin
            code_d = 16'h7FC0;                       // quiet NaN
        end else if (spec_i[S_PINF]) begin
            code_d = 16'h7F80;                       // +inf
        end else if (spec_i[S_PZER]) begin
            code_d = 16'hFF80;                       // log(0) = -inf
        end else begin
            special_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v1_q      <= 1'b0;
            sign_q    <= 1'b0;
            mag_q     <= '0;
            special_q <= 1'b0;
            code_q    <= 16'h0000;
        end else begin
            if (en1) v1_q <= valid_i;
            if (en1 & valid_i) begin
                sign_q    <= sign_d;
                mag_q     <= mag_d;
                special_q <= special_d;
                code_q    <= code_d;
            end
        end
    end

    // ---------------- stage 2: normalize and round ----------------
    logic [LW-1:0]          lead;
    logic [DIM-1:0]         norm;
    logic [FRACT_WIDTH-1:0] mant_raw;
    logic                   guard, sticky, round_up;
    logic [FRACT_WIDTH:0]   mant_sum;
    logic [8:0]             exp9;
    logic [15:0]            result_d, result_q;

    always_comb begin
        lead = '0;
        for (int i = 0; i < DIM; i++) begin
            if (mag_q[i]) lead = LW'(i);
        end
    end

    // Left-justify so the leading one sits in the MSB; bits below it are the
    // mantissa, guard and sticky (zero-padded automatically for small p).
    assign norm     = mag_q << (LW'(DIM - 1) - lead);
    assign mant_raw = norm[DIM-2 -: FRACT_WIDTH];
    assign guard    = norm[DIM-2-FRACT_WIDTH];
    assign sticky   = |norm[DIM-3-FRACT_WIDTH:0];
    assign round_up = guard & (sticky | mant_raw[0]);
    assign mant_sum = {1'b0, mant_raw} + (FRACT_WIDTH+1)'(round_up);
    // A mantissa carry-out leaves the low bits zero and bumps the exponent.
    assign exp9     = 9'(BIAS - COMMA_POS) + 9'(lead) + 9'(mant_sum[FRACT_WIDTH]);

    always_comb begin
        result_d = 16'h0000;
        if (special_q) begin
            result_d = code_q;
        end else if (mag_q != '0) begin
            result_d = {sign_q, exp9[EXP_WIDTH-1:0], mant_sum[FRACT_WIDTH-1:0]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v2_q     <= 1'b0;
            result_q <= 16'h0000;
        end else begin
            if (en2) v2_q <= v1_q;
            if (en2 & v1_q) result_q <= result_d;
        end
    end

    assign result_o = result_q;

`ifdef FLOG_PACK_STATUS_EN
    logic       invalid_d, invalid_q, divzero_q;
    logic [2:0] flags_q;

    assign invalid_d = spec_i[S_SNAN] | spec_i[S_NEG];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            invalid_q <= 1'b0;
            divzero_q <= 1'b0;
            flags_q   <= 3'b000;
        end else begin
            if (en1 & valid_i) begin
                invalid_q <= invalid_d;
                divzero_q <= spec_i[S_PZER];
            end
            if (en2 & v1_q) begin
                flags_q <= {invalid_q, divzero_q, ~special_q & (guard | sticky)};
            end
        end
    end

    assign flags_o = flags_q;
`endif

    // isOpValid and the exponent sign bit carry no information here.
    logic unused_bits;
    assign unused_bits = ^{spec_i[0], exp9[8]};

endmodule

// File: tb/tb_flog_out_packer.sv
// -----------------------------------------------------------------------------
// tb_flog_out_packer
//   Self-checking bench for flog_out_packer. An arithmetic reference model
//   computes the expected bfloat16 word for every accepted input; a compare
//   process on the falling edge checks ready_o, valid_o ordering and result_o
//   against a queue of expected words. Directed cases pin the model itself.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_flog_out_packer;

    typedef struct packed {
        logic [15:0] r;
        logic [2:0]  f;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [21:0] res_i;
    logic [5:0]  spec_i;
    logic        valid_o;
    logic        ready_i;
    logic [15:0] result_o;
`ifdef FLOG_PACK_STATUS_EN
    logic [2:0]  flags_o;
`endif

    int checks   = 0;
    int failures = 0;
    exp_t exp_q[$];

    always #5 clk_i = ~clk_i;

    flog_out_packer dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .res_i    (res_i),
        .spec_i   (spec_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o)
`ifdef FLOG_PACK_STATUS_EN
        ,
        .flags_o  (flags_o)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: value = res / 2^14, rounded to 8 significant bits (RNE).
    function automatic exp_t model(input logic [21:0] res, input logic [5:0] spec);
        exp_t   e;
        longint v, mag, num, q, rem, unit;
        int     p, ex;
        bit     sign;
        e.r = 16'h0000;
        e.f = {spec[1] | spec[5], spec[3], 1'b0};
        if (spec[1] | spec[2] | spec[5]) e.r = 16'h7FC0;
        else if (spec[4])                e.r = 16'h7F80;
        else if (spec[3])                e.r = 16'hFF80;
        else begin
            v    = longint'($signed(res));
            sign = (v < 0);
            mag  = sign ? -v : v;
            if (mag != 0) begin
                p = 0;
                while ((longint'(1) << (p + 1)) <= mag) p++;
                num  = mag * 128;
                unit = longint'(1) << p;
                q    = num >> p;
                rem  = num - q * unit;
                if (2 * rem > unit || (2 * rem == unit && (q % 2) == 1)) q++;
                ex = 127 + p - 14;
                if (q == 256) begin
                    q  = 128;
                    ex = ex + 1;
                end
                e.r    = {sign, 8'(ex), 7'(q)};
                e.f[0] = (rem != 0);
            end
        end
        return e;
    endfunction

    // Falling-edge scoreboard: inputs change just after the rising edge, so
    // what is seen here is what the next rising edge will act on.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            check("ready_o", ready_o, (exp_q.size() < 2) | ready_i);
            if (exp_q.size() == 0) begin
                check("no_spurious_valid_o", valid_o, 1'b0);
            end else if (valid_o) begin
                check("result_o", result_o, exp_q[0].r);
`ifdef FLOG_PACK_STATUS_EN
                check("flags_o", flags_o, exp_q[0].f);
`endif
                if (ready_i) void'(exp_q.pop_front());
            end
            if (valid_i && ready_o) exp_q.push_back(model(res_i, spec_i));
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Present one beat and hold it until the DUT takes it (bounded).
    task automatic send(input logic [21:0] r, input logic [5:0] s);
        bit taken = 0;
        valid_i = 1'b1;
        res_i   = r;
        spec_i  = s;
        for (int n = 0; n < 20 && !taken; n++) begin
            @(negedge clk_i);
            taken = ready_o;
            step();
        end
        if (!taken) check("send_accepted", 32'(taken), 32'd1);
        valid_i = 1'b0;
    endtask

    function automatic logic [21:0] rand_res();
        logic [31:0] r;
        r = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) r = -r;
        return 22'(r);
    endfunction

    logic [21:0] d_res  [10] = '{22'h004000, 22'h3FE000, 22'h004090, 22'h0040C0, 22'h007FFF,
                                 22'h200000, 22'h000000, 22'h000001, 22'h1234AB, 22'h000000};
    logic [5:0]  d_spec [10] = '{6'b000001, 6'b000001, 6'b000001, 6'b000001, 6'b000001,
                                 6'b000001, 6'b000001, 6'b000001, 6'b001000, 6'b100000};
    logic [15:0] d_exp  [10] = '{16'h3F80, 16'hBF00, 16'h3F81, 16'h3F82, 16'h4000,
                                 16'hC300, 16'h0000, 16'h3880, 16'hFF80, 16'h7FC0};

    initial begin
        logic [15:0] held;
        int n;
        rst_i   = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        res_i   = '0;
        spec_i  = '0;
        #1;
        check("reset_valid_o", valid_o, 1'b0);
        check("reset_result_o", result_o, 16'h0000);
        check("reset_ready_o", ready_o, 1'b1);
        step();
        step();
        rst_i = 1'b0;
        step();

        // Model pins against hand-computed words.
        for (int i = 0; i < 10; i++) check($sformatf("model_pin_%0d", i), model(d_res[i], d_spec[i]).r, d_exp[i]);
        check("model_pin_inexact", model(22'h004090, 6'b000001).f, 3'b001);
        check("model_pin_tie_exact", model(22'h0040C0, 6'b000001).f, 3'b001);
        check("model_pin_pinf", model(22'h0, 6'b010000).r, 16'h7F80);
        check("model_pin_snan", model(22'h0, 6'b000010).r, 16'h7FC0);

        // Two-cycle latency.
        valid_i = 1'b1;
        res_i   = 22'h004000;
        spec_i  = 6'b000001;
        step();
        valid_i = 1'b0;
        check("latency_not_early", valid_o, 1'b0);
        step();
        check("latency_valid_o", valid_o, 1'b1);
        check("latency_result_o", result_o, 16'h3F80);
        step();

        // Directed patterns and special codes through the DUT.
        for (int i = 0; i < 10; i++) send(d_res[i], d_spec[i]);
        send(22'h0, 6'b010000);
        send(22'h0, 6'b000010);
        send(22'h0, 6'b000100);
        repeat (4) step();

        // Backpressure: three beats, only two fit.
        ready_i = 1'b0;
        valid_i = 1'b1;
        res_i   = 22'h004000; spec_i = 6'b000001; step();
        res_i   = 22'h3FE000; step();
        res_i   = 22'h007FFF; step();
        #3;
        check("bp_full_ready_o", ready_o, 1'b0);
        held = result_o;
        repeat (3) step();
        check("bp_valid_held", valid_o, 1'b1);
        check("bp_result_stable", result_o, held);
        ready_i = 1'b1;
        step();
        valid_i = 1'b0;
        repeat (4) step();

        // Reset with both stages full.
        ready_i = 1'b0;
        valid_i = 1'b1;
        res_i   = 22'h004090; step();
        res_i   = 22'h0040C0; step();
        valid_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        exp_q.delete();
        check("midrst_valid_o", valid_o, 1'b0);
        check("midrst_result_o", result_o, 16'h0000);
        step();
        rst_i   = 1'b0;
        ready_i = 1'b1;
        repeat (5) step();

        // Random traffic with random backpressure.
        for (int c = 0; c < 800; c++) begin
            valid_i = ($urandom_range(0, 9) < 7);
            ready_i = ($urandom_range(0, 9) < 6);
            res_i   = rand_res();
            spec_i  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b000001;
            step();
        end

        // Drain (bounded).
        valid_i = 1'b0;
        ready_i = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            step();
            n++;
        end
        check("drain_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
